// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two-source byte FIFO arbiter feeding uart_tx on dot_clk.
// Each producer's one-cycle byte strobes are buffered in a private circular FIFO.
// The two streams are interleaved round-robin. uart_tx gets one i_Tx_DV pulse per byte,
// and the arbiter waits for o_Tx_Done before it offers the next byte.
// Optional build macro: UART_TX_ARB_STATS_EN enables saturating per-source drop counters.
// Without the macro, a_drop_cnt and b_drop_cnt are tied to 8'h00.
module uart_tx_arbiter #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] a_byte,
  input  logic       a_valid,
  input  logic [7:0] b_byte,
  input  logic       b_valid,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  input  logic       tx_done,
  output logic       a_full,
  output logic       b_full,
  output logic       a_drop,
  output logic       b_drop,
  output logic [7:0] a_drop_cnt,
  output logic [7:0] b_drop_cnt
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STROBE = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  logic [7:0]            r_a_mem [DEPTH];
  logic [7:0]            r_b_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_a_wr, r_a_rd, r_b_wr, r_b_rd;
  logic [DEPTH_LOG2:0]   r_a_cnt, r_b_cnt;
  logic [1:0]            r_state;
  logic [7:0]            r_tx_byte;
  logic                  r_rr_last;
  logic                  r_a_drop, r_b_drop;

  logic w_a_full, w_b_full, w_a_ne, w_b_ne;
  logic w_a_push, w_b_push, w_a_pop, w_b_pop, w_idle;

  // Count never exceeds DEPTH, so its MSB alone flags a full FIFO.
  assign w_a_full = r_a_cnt[DEPTH_LOG2];
  assign w_b_full = r_b_cnt[DEPTH_LOG2];
  assign w_a_ne   = |r_a_cnt;
  assign w_b_ne   = |r_b_cnt;

  // Fullness is judged before any pop in the same cycle, so a pop never makes room early.
  assign w_a_push = a_valid && !w_a_full;
  assign w_b_push = b_valid && !w_b_full;

  // Round-robin: A wins when only A has data or when B was served last.
  assign w_idle  = (r_state == ST_IDLE);
  assign w_a_pop = w_idle && w_a_ne && (!w_b_ne || (r_rr_last == SRC_B));
  assign w_b_pop = w_idle && w_b_ne && !w_a_pop;

  // FIFO storage writes; storage needs no reset because the pointers gate it.
  always_ff @(posedge clk) begin
    if (w_a_push) r_a_mem[r_a_wr] <= a_byte;
    if (w_b_push) r_b_mem[r_b_wr] <= b_byte;
  end

  // Source A pointer and occupancy tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_wr  <= '0;
      r_a_rd  <= '0;
      r_a_cnt <= '0;
    end else begin
      if (w_a_push) r_a_wr <= r_a_wr + PTR_ONE;
      if (w_a_pop)  r_a_rd <= r_a_rd + PTR_ONE;
      case ({w_a_push, w_a_pop})
        2'b10:   r_a_cnt <= r_a_cnt + CNT_ONE;
        2'b01:   r_a_cnt <= r_a_cnt - CNT_ONE;
        default: r_a_cnt <= r_a_cnt;
      endcase
    end
  end

  // Source B pointer and occupancy tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_b_wr  <= '0;
      r_b_rd  <= '0;
      r_b_cnt <= '0;
    end else begin
      if (w_b_push) r_b_wr <= r_b_wr + PTR_ONE;
      if (w_b_pop)  r_b_rd <= r_b_rd + PTR_ONE;
      case ({w_b_push, w_b_pop})
        2'b10:   r_b_cnt <= r_b_cnt + CNT_ONE;
        2'b01:   r_b_cnt <= r_b_cnt - CNT_ONE;
        default: r_b_cnt <= r_b_cnt;
      endcase
    end
  end

  // Pacing FSM: pop a head into tx_byte, strobe once, then hold until uart_tx reports done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_tx_byte <= 8'h00;
      r_rr_last <= SRC_B;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_a_pop) begin
            r_tx_byte <= r_a_mem[r_a_rd];
            r_rr_last <= SRC_A;
            r_state   <= ST_STROBE;
          end else if (w_b_pop) begin
            r_tx_byte <= r_b_mem[r_b_rd];
            r_rr_last <= SRC_B;
            r_state   <= ST_STROBE;
          end
        end
        ST_STROBE: r_state <= ST_WAIT;
        ST_WAIT:   if (tx_done) r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Drop pulses appear the cycle after a write that found its FIFO full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_drop <= 1'b0;
      r_b_drop <= 1'b0;
    end else begin
      r_a_drop <= a_valid && w_a_full;
      r_b_drop <= b_valid && w_b_full;
    end
  end

`ifdef UART_TX_ARB_STATS_EN
  logic [7:0] r_a_drop_cnt, r_b_drop_cnt;

  // Saturating rejected-write counters, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_drop_cnt <= 8'h00;
      r_b_drop_cnt <= 8'h00;
    end else begin
      if (a_valid && w_a_full && (r_a_drop_cnt != 8'hFF)) r_a_drop_cnt <= r_a_drop_cnt + 8'h01;
      if (b_valid && w_b_full && (r_b_drop_cnt != 8'hFF)) r_b_drop_cnt <= r_b_drop_cnt + 8'h01;
    end
  end

  assign a_drop_cnt = r_a_drop_cnt;
  assign b_drop_cnt = r_b_drop_cnt;
`else
  assign a_drop_cnt = 8'h00;
  assign b_drop_cnt = 8'h00;
`endif

  // tx_valid is decoded from state so an asynchronous reset clears it immediately.
  assign tx_valid = (r_state == ST_STROBE);
  assign tx_byte  = r_tx_byte;
  assign a_full   = w_a_full;
  assign b_full   = w_b_full;
  assign a_drop   = r_a_drop;
  assign b_drop   = r_b_drop;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, latency, round-robin order, overflow,
// simultaneous writes, mid-operation reset and drop statistics.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] a_byte = 8'h00;
  logic       a_valid = 1'b0;
  logic [7:0] b_byte = 8'h00;
  logic       b_valid = 1'b0;
  logic       tx_done = 1'b0;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       a_full, b_full, a_drop, b_drop;
  logic [7:0] a_drop_cnt, b_drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef UART_TX_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_tx_arbiter #(.DEPTH_LOG2(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .a_byte     (a_byte),
    .a_valid    (a_valid),
    .b_byte     (b_byte),
    .b_valid    (b_valid),
    .tx_byte    (tx_byte),
    .tx_valid   (tx_valid),
    .tx_done    (tx_done),
    .a_full     (a_full),
    .b_full     (b_full),
    .a_drop     (a_drop),
    .b_drop     (b_drop),
    .a_drop_cnt (a_drop_cnt),
    .b_drop_cnt (b_drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    tx_done = 1'b0;
    steps(2);
    reset = 1'b0;
  endtask

  task automatic write_a(input logic [7:0] d);
    a_valid = 1'b1;
    a_byte  = d;
    step();
    a_valid = 1'b0;
  endtask

  task automatic write_b(input logic [7:0] d);
    b_valid = 1'b1;
    b_byte  = d;
    step();
    b_valid = 1'b0;
  endtask

  // Wait (bounded) for a strobe, check its byte, then confirm it lasts one cycle.
  task automatic expect_tx(input string tag, input logic [7:0] exp);
    for (int i = 0; i < 20; i++) begin
      if (tx_valid) break;
      step();
    end
    check({tag, "_valid"}, 32'(tx_valid), 32'd1);
    check({tag, "_byte"}, 32'(tx_byte), 32'(exp));
    step();
    check({tag, "_pulse"}, 32'(tx_valid), 32'd0);
  endtask

  task automatic done_pulse();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  // Returns whether any tx_valid was seen over n samples.
  task automatic watch_quiet(input int n, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (tx_valid) seen = 1'b1;
      step();
    end
  endtask

  bit seen;

  initial begin
    // 1: reset state, stale tx_done, single byte latency and hold.
    do_reset();
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'h00);
    check("rst_a_full", 32'(a_full), 32'd0);
    check("rst_drops", {30'd0, a_drop, b_drop}, 32'd0);
    check("rst_cnts", {16'd0, a_drop_cnt, b_drop_cnt}, 32'd0);
    done_pulse();
    check("stale_done", 32'(tx_valid), 32'd0);
    write_a(8'h41);
    check("t1_n1", 32'(tx_valid), 32'd0);
    step();
    check("t1_n2_valid", 32'(tx_valid), 32'd1);
    check("t1_n2_byte", 32'(tx_byte), 32'h41);
    step();
    check("t1_one_pulse", 32'(tx_valid), 32'd0);
    steps(4);
    check("t1_hold_byte", 32'(tx_byte), 32'h41);
    check("t1_no_repeat", 32'(tx_valid), 32'd0);
    done_pulse();

    // 2: round-robin interleave with rr_last=B when the preload is released.
    do_reset();
    write_b(8'h5A);
    expect_tx("t2_first", 8'h5A);
    a_valid = 1'b1; a_byte = 8'h10; b_valid = 1'b1; b_byte = 8'h20;
    step();
    a_byte = 8'h11; b_byte = 8'h21;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    steps(2);
    check("t2_wait_quiet", 32'(tx_valid), 32'd0);
    done_pulse();
    expect_tx("t2_o0", 8'h10);
    done_pulse();
    expect_tx("t2_o1", 8'h20);
    done_pulse();
    expect_tx("t2_o2", 8'h11);
    done_pulse();
    expect_tx("t2_o3", 8'h21);
    done_pulse();
    check("t2_no_drop", {30'd0, a_drop, b_drop}, 32'd0);

    // 3: overflow of source A while uart_tx is busy.
    do_reset();
    write_b(8'h77);
    expect_tx("t3_busy", 8'h77);
    for (int i = 0; i < 17; i++) begin
      a_valid = 1'b1;
      a_byte  = 8'(i);
      step();
      if (i == 14) check("t3_not_full_15", 32'(a_full), 32'd0);
      if (i == 15) begin
        check("t3_full_16", 32'(a_full), 32'd1);
        check("t3_no_drop_16", 32'(a_drop), 32'd0);
      end
      if (i == 16) check("t3_drop_17", 32'(a_drop), 32'd1);
    end
    a_valid = 1'b0;
    step();
    check("t3_drop_clear", 32'(a_drop), 32'd0);
    check("t3_still_full", 32'(a_full), 32'd1);
    check("t3_a_cnt", 32'(a_drop_cnt), STATS ? 32'd1 : 32'd0);
    done_pulse();
    for (int i = 0; i < 16; i++) begin
      expect_tx($sformatf("t3_drain%0d", i), 8'(i));
      done_pulse();
    end
    watch_quiet(8, seen);
    check("t3_no_17th", 32'(seen), 32'd0);
    check("t3_empty_not_full", 32'(a_full), 32'd0);

    // 4: simultaneous writes; tx_done during STROBE is ignored.
    do_reset();
    a_valid = 1'b1; a_byte = 8'hA1; b_valid = 1'b1; b_byte = 8'hB1;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    check("t4_first_valid", 32'(tx_valid), 32'd1);
    check("t4_first_byte", 32'(tx_byte), 32'hA1);
    done_pulse();
    check("t4_after_strobe", 32'(tx_valid), 32'd0);
    watch_quiet(6, seen);
    check("t4_done_ignored", 32'(seen), 32'd0);
    done_pulse();
    expect_tx("t4_second", 8'hB1);
    done_pulse();
    check("t4_no_drop", {30'd0, a_drop, b_drop}, 32'd0);

    // 5: reset mid-operation with three bytes queued.
    do_reset();
    write_a(8'h01);
    expect_tx("t5_busy", 8'h01);
    write_a(8'h02);
    write_a(8'h03);
    write_b(8'h04);
    step();
    reset = 1'b1;
    #1;
    check("t5_async_valid", 32'(tx_valid), 32'd0);
    check("t5_async_byte", 32'(tx_byte), 32'h00);
    step();
    reset = 1'b0;
    done_pulse();
    watch_quiet(10, seen);
    check("t5_flushed", 32'(seen), 32'd0);
    write_a(8'h55);
    check("t5_n1", 32'(tx_valid), 32'd0);
    step();
    check("t5_n2_valid", 32'(tx_valid), 32'd1);
    check("t5_n2_byte", 32'(tx_byte), 32'h55);
    step();
    done_pulse();

    // 6: 300 rejected B writes saturate the counter in the stats build.
    do_reset();
    write_a(8'h01);
    expect_tx("t6_busy", 8'h01);
    for (int i = 0; i < 316; i++) begin
      b_valid = 1'b1;
      b_byte  = 8'(i);
      step();
      if (i == 20) check("t6_cnt_5", 32'(b_drop_cnt), STATS ? 32'd5 : 32'd0);
    end
    check("t6_b_full", 32'(b_full), 32'd1);
    check("t6_b_drop", 32'(b_drop), 32'd1);
    b_valid = 1'b0;
    step();
    check("t6_b_drop_clear", 32'(b_drop), 32'd0);
    check("t6_b_cnt_sat", 32'(b_drop_cnt), STATS ? 32'hFF : 32'h00);
    check("t6_a_cnt", 32'(a_drop_cnt), 32'h00);
    done_pulse();
    expect_tx("t6_b_head", 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
